// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one external ALU between two requesters
// Optional macro: ALU_SHARE_ARBITER_PERF_EN adds saturating grant/stall counters.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result
`ifdef ALU_SHARE_ARBITER_PERF_EN
    ,
    output logic [15:0]           perf_grant0,
    output logic [15:0]           perf_grant1,
    output logic [15:0]           perf_stall
`endif
);

    logic                  r_ex_valid;
    logic                  r_ex_id;
    logic [OP_WIDTH-1:0]   r_alu_op;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic                  r_rsp_valid;
    logic                  r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic                  r_last_grant;

    logic w_rsp_free;
    logic w_ex_move;
    logic w_ex_free;
    logic w_gnt_id;
    logic w_acc0;
    logic w_acc1;
    logic w_accept;

    // Pipeline advance terms and round-robin grant; ready is forced low during reset.
    always_comb begin
        w_rsp_free = !r_rsp_valid || rsp_ready;
        w_ex_move  = r_ex_valid && w_rsp_free;
        w_ex_free  = !r_ex_valid || w_ex_move;
        // Both valid: the port not served last wins; otherwise the lone valid port wins.
        if (req0_valid && req1_valid) begin
            w_gnt_id = !r_last_grant;
        end else begin
            w_gnt_id = req1_valid;
        end
        req0_ready = reset && w_ex_free && req0_valid && !w_gnt_id;
        req1_ready = reset && w_ex_free && req1_valid && w_gnt_id;
        w_acc0     = req0_valid && req0_ready;
        w_acc1     = req1_valid && req1_ready;
        w_accept   = w_acc0 || w_acc1;
    end

    // EX stage (ALU operand register) and RSP stage (captured result) with grant history.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ex_valid   <= 1'b0;
            r_ex_id      <= 1'b0;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_accept) begin
                r_ex_valid   <= 1'b1;
                r_ex_id      <= w_acc1;
                r_last_grant <= w_acc1;
                r_alu_op     <= w_acc1 ? req1_op : req0_op;
                r_alu_a      <= w_acc1 ? req1_a  : req0_a;
                r_alu_b      <= w_acc1 ? req1_b  : req0_b;
            end else if (w_ex_move) begin
                r_ex_valid <= 1'b0;
            end
            if (w_ex_move) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_id     <= r_ex_id;
                r_rsp_result <= alu_result;
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;

`ifdef ALU_SHARE_ARBITER_PERF_EN
    logic [15:0] r_perf_grant0;
    logic [15:0] r_perf_grant1;
    logic [15:0] r_perf_stall;

    // Saturating event counters: accepted handshakes per port and response-stall cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_grant0 <= '0;
            r_perf_grant1 <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_acc0 && (r_perf_grant0 != 16'hFFFF)) begin
                r_perf_grant0 <= r_perf_grant0 + 16'd1;
            end
            if (w_acc1 && (r_perf_grant1 != 16'hFFFF)) begin
                r_perf_grant1 <= r_perf_grant1 + 16'd1;
            end
            if (r_rsp_valid && !rsp_ready && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign perf_grant0 = r_perf_grant0;
    assign perf_grant1 = r_perf_grant1;
    assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
`ifdef ALU_SHARE_ARBITER_PERF_EN
    logic [15:0] perf_grant0, perf_grant1, perf_stall;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // External ALU model: 0 and, 1 or, 2 add, 6 sub, 7 xor.
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a & alu_b;
            4'd1:    alu_result = alu_a | alu_b;
            4'd2:    alu_result = alu_a + alu_b;
            4'd6:    alu_result = alu_a - alu_b;
            4'd7:    alu_result = alu_a ^ alu_b;
            default: alu_result = 32'd0;
        endcase
    end

    alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
`ifdef ALU_SHARE_ARBITER_PERF_EN
        ,
        .perf_grant0(perf_grant0),
        .perf_grant1(perf_grant1),
        .perf_stall (perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd9; req0_b = 32'd9;
        req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'd9; req1_b = 32'd9;
        step(); step();

        // Reset state
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);

        // Single op: add 5+7 from port 0
        req1_valid = 1'b0;
        reset = 1'b1; req0_op = 4'd2; req0_a = 32'd5; req0_b = 32'd7;
        settle();
        chk("single_ready0", {31'd0, req0_ready}, 32'd1);
        chk("single_ready1", {31'd0, req1_ready}, 32'd0);
        step(); req0_valid = 1'b0;
        chk("single_alu_op", {28'd0, alu_op}, 32'd2);
        chk("single_alu_a", alu_a, 32'd5);
        chk("single_alu_b", alu_b, 32'd7);
        chk("single_rsp_early", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("single_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("single_rsp_result", rsp_result, 32'd12);
        step();
        chk("single_drain", {31'd0, rsp_valid}, 32'd0);
        chk("idle_alu_hold", alu_a, 32'd5);

        // Simultaneous drain and refill: two back-to-back port 0 ops
        req0_valid = 1'b1; req0_op = 4'd6; req0_a = 32'd20; req0_b = 32'd3;
        step();
        req0_op = 4'd0; req0_a = 32'hF0; req0_b = 32'h3C;
        settle();
        chk("refill_ready0", {31'd0, req0_ready}, 32'd1);
        step(); req0_valid = 1'b0;
        chk("refill_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("refill_rsp1", rsp_result, 32'd17);
        step();
        chk("refill_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("refill_rsp2", rsp_result, 32'h30);
        step();
        chk("refill_drain", {31'd0, rsp_valid}, 32'd0);

        // Backpressure: three port 1 ops while the consumer stalls
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'd1; req1_b = 32'd2;
        settle();
        chk("bp_ready1_a", {31'd0, req1_ready}, 32'd1);
        step();
        req1_op = 4'd2; req1_a = 32'd100; req1_b = 32'd1;
        settle();
        chk("bp_ready1_b", {31'd0, req1_ready}, 32'd1);
        step();
        req1_op = 4'd7; req1_a = 32'hFF; req1_b = 32'h0F;
        settle();
        chk("bp_stall_ready1", {31'd0, req1_ready}, 32'd0);
        chk("bp_stall_ready0", {31'd0, req0_ready}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_hold_result", rsp_result, 32'd3);
            chk("bp_hold_id", {31'd0, rsp_id}, 32'd1);
            chk("bp_hold_alu_a", alu_a, 32'd100);
            chk("bp_hold_alu_op", {28'd0, alu_op}, 32'd2);
            chk("bp_hold_ready1", {31'd0, req1_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        settle();
        chk("bp_release_ready1", {31'd0, req1_ready}, 32'd1);
        step(); req1_valid = 1'b0;
        chk("bp_drain_y", rsp_result, 32'h65);
        chk("bp_drain_y_valid", {31'd0, rsp_valid}, 32'd1);
        step();
        chk("bp_drain_z", rsp_result, 32'hF0);
        chk("bp_drain_z_id", {31'd0, rsp_id}, 32'd1);
        step();
        chk("bp_empty", {31'd0, rsp_valid}, 32'd0);

        // Round-robin: both valid, last grant was port 1 so port 0 goes first
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd1;  req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'd10; req1_b = 32'd10;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rr_ready0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            step();
            if (k >= 1) begin
                chk("rr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("rr_rsp_id", {31'd0, rsp_id}, ((k - 1) % 2 == 1) ? 32'd1 : 32'd0);
                chk("rr_rsp_result", rsp_result, ((k - 1) % 2 == 1) ? 32'd20 : 32'd2);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk("rr_last_id", {31'd0, rsp_id}, 32'd1);
        chk("rr_last_result", rsp_result, 32'd20);
        step();
        chk("rr_empty", {31'd0, rsp_valid}, 32'd0);

`ifdef ALU_SHARE_ARBITER_PERF_EN
        chk("perf_grant0", {16'd0, perf_grant0}, 32'd5);
        chk("perf_grant1", {16'd0, perf_grant1}, 32'd5);
        chk("perf_stall", {16'd0, perf_stall}, 32'd2);
`endif

        // Reset mid-flight with both stages full
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd40; req0_b = 32'd2;
        step(); step();
        req0_valid = 1'b0;
        chk("mid_full", {31'd0, rsp_valid}, 32'd1);
        reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        settle();
        chk("mid_rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("mid_rst_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_alu_op", {28'd0, alu_op}, 32'd0);
`ifdef ALU_SHARE_ARBITER_PERF_EN
        chk("mid_rst_perf0", {16'd0, perf_grant0}, 32'd0);
        chk("mid_rst_stall", {16'd0, perf_stall}, 32'd0);
`endif
        reset = 1'b1; rsp_ready = 1'b1;
        req0_op = 4'd7; req0_a = 32'hAA; req0_b = 32'h0F;
        settle();
        chk("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
        step(); req0_valid = 1'b0; req1_valid = 1'b0;
        chk("post_rst_no_stale", {31'd0, rsp_valid}, 32'd0);
        chk("post_rst_alu_a", alu_a, 32'hAA);
        step();
        chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("post_rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("post_rst_rsp_result", rsp_result, 32'hA5);
        step();
        chk("post_rst_empty", {31'd0, rsp_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
